swc_rd_sched: RTL and testbench

- Parametrised read-side scheduler for the shared-buffer switch core: an N-port successor to the fixed 4-port, 6-state cell read machine.
- Arbitrates round-robin among per-port output queue controllers and reads each granted cell from the data SRAM beat by beat.
- Delivers each beat to the selected output cell FIFO.
- Maintains the multicast reference-count RAM and returns a cell pointer to the free queue after its last reader.
- Cells stream back-to-back with no idle gap between cells, which the previous block did not do.

---
 rtl/swc_rd_sched.sv | 194 +++++++++++++++++++
 tb/tb_swc_rd_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swc_rd_sched.sv
// swc_rd_sched: round-robin cell read scheduler with multicast ref counting.
// Define SWC_PKT_LOCK_EN to hold a port's grant until its packet's last cell.
module swc_rd_sched #(
    parameter int NPORT   = 4,
    parameter int PTR_W   = 10,
    parameter int BEAT_W  = 2,
    parameter int DATA_W  = 128,
    parameter int MC_W    = 4,
    parameter int RAM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NPORT-1:0]        q_rdy,
    input  logic [NPORT*16-1:0]     q_ptr,
    output logic [NPORT-1:0]        q_ack,
    input  logic [NPORT-1:0]        o_bp,
    input  logic                    mc_wr,
    input  logic [PTR_W-1:0]        mc_addr,
    input  logic [MC_W-1:0]         mc_cnt,
    output logic                    sram_rd,
    output logic [PTR_W+BEAT_W-1:0] sram_addr,
    input  logic [DATA_W-1:0]       sram_dout,
    output logic [NPORT-1:0]        o_wr,
    output logic [DATA_W-1:0]       o_din,
    output logic                    o_first,
    output logic                    o_last,
    output logic                    fq_wr,
    output logic [PTR_W-1:0]        fq_din,
    output logic                    err_mc
);
    localparam int IDX_W = $clog2(NPORT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = '1;
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nx;

    logic [BEAT_W-1:0] beat;
    logic [IDX_W-1:0]  rr_ptr, cur_g;
    logic [PTR_W-1:0]  cur_ptr;
    logic              cur_first, cur_last;
    logic [NPORT-1:0]  cur_oh;

    logic [NPORT-1:0]  elig;
    logic              arb_en, gnt_vld;
    logic [IDX_W:0]    idx;
    logic [IDX_W-1:0]  gnt_g, gnt_rr;
    logic [PTR_W-1:0]  gnt_ptr;
    logic              gnt_first, gnt_last;

`ifdef SWC_PKT_LOCK_EN
    logic              lock_vld;
    logic [IDX_W-1:0]  lock_g;
`endif

    always_comb begin
        elig    = q_rdy & ~o_bp;
        arb_en  = (state == IDLE) || (beat == BEAT_LAST);
        gnt_vld = 1'b0;
        gnt_g   = '0;
        idx     = '0;
        for (int i = 0; i < NPORT; i++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NPORT))
                idx = idx - (IDX_W+1)'(NPORT);
            if (!gnt_vld && elig[idx[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_g   = idx[IDX_W-1:0];
            end
        end
`ifdef SWC_PKT_LOCK_EN
        if (lock_vld && elig[lock_g]) begin
            gnt_vld = 1'b1;
            gnt_g   = lock_g;
        end
`endif
        gnt_ptr   = q_ptr[{gnt_g, 4'd0} +: PTR_W];
        gnt_first = q_ptr[{gnt_g, 4'd14}];
        gnt_last  = q_ptr[{gnt_g, 4'd15}];
        gnt_rr    = (gnt_g == IDX_W'(NPORT-1)) ? '0 : gnt_g + IDX_W'(1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_vld) state_nx = READ;
            READ:    if (beat == BEAT_LAST) state_nx = gnt_vld ? READ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            beat      <= '0;
            rr_ptr    <= '0;
            cur_g     <= '0;
            cur_ptr   <= '0;
            cur_first <= 1'b0;
            cur_last  <= 1'b0;
        end else begin
            state <= state_nx;
            beat  <= (state == READ) ? beat + BEAT_ONE : '0;
            if (arb_en && gnt_vld) begin
                rr_ptr    <= gnt_rr;
                cur_g     <= gnt_g;
                cur_ptr   <= gnt_ptr;
                cur_first <= gnt_first;
                cur_last  <= gnt_last;
            end
        end
    end

`ifdef SWC_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_vld <= 1'b0;
            lock_g   <= '0;
        end else if (arb_en && gnt_vld) begin
            if (!gnt_last) begin
                lock_vld <= 1'b1;
                lock_g   <= gnt_g;
            end else if (gnt_g == lock_g) begin
                lock_vld <= 1'b0;
            end
        end
    end
`endif

    assign cur_oh    = {{(NPORT-1){1'b0}}, 1'b1} << cur_g;
    assign sram_rd   = (state == READ);
    assign sram_addr = sram_rd ? {cur_ptr, beat} : '0;
    assign q_ack     = (sram_rd && beat == '0) ? cur_oh : '0;

    // Beat attributes ride alongside the SRAM read latency.
    logic [RAM_LAT-1:0]            p_vld, p_first, p_last;
    logic [RAM_LAT-1:0][NPORT-1:0] p_oh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_vld   <= '0;
            p_first <= '0;
            p_last  <= '0;
            p_oh    <= '0;
        end else begin
            p_vld[0]   <= sram_rd;
            p_first[0] <= cur_first;
            p_last[0]  <= cur_last;
            p_oh[0]    <= cur_oh;
            for (int k = 1; k < RAM_LAT; k++) begin
                p_vld[k]   <= p_vld[k-1];
                p_first[k] <= p_first[k-1];
                p_last[k]  <= p_last[k-1];
                p_oh[k]    <= p_oh[k-1];
            end
        end
    end

    assign o_wr    = p_vld[RAM_LAT-1] ? p_oh[RAM_LAT-1] : '0;
    assign o_din   = p_vld[RAM_LAT-1] ? sram_dout : '0;
    assign o_first = p_vld[RAM_LAT-1] & p_first[RAM_LAT-1];
    assign o_last  = p_vld[RAM_LAT-1] & p_last[RAM_LAT-1];

    logic [MC_W-1:0] cnt_mem [2**PTR_W];
    logic [MC_W-1:0] cnt_q;
    logic            b_chk, b_we, b_hit;

    assign b_chk = sram_rd && (beat == BEAT_ONE);
    assign b_we  = b_chk && (cnt_q != '0);
    assign b_hit = b_we && mc_wr && (mc_addr == cur_ptr);

    // Write side is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (sram_rd && beat == '0)
            cnt_q <= cnt_mem[cur_ptr];
        if (b_we)
            cnt_mem[cur_ptr] <= cnt_q - MC_W'(1);
        if (mc_wr)
            cnt_mem[mc_addr] <= mc_cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq_wr  <= 1'b0;
            fq_din <= '0;
            err_mc <= 1'b0;
        end else begin
            fq_wr  <= b_chk && (cnt_q == MC_W'(1));
            fq_din <= (b_chk && cnt_q == MC_W'(1)) ? cur_ptr : '0;
            if ((b_chk && cnt_q == '0) || b_hit)
                err_mc <= 1'b1;
        end
    end
endmodule

// File: tb/tb_swc_rd_sched.sv
// tb_swc_rd_sched: directed bench with queue/SRAM models and a beat scoreboard.
// Grant order, pointer returns and ref counts are predicted from the scheduling rules.
`timescale 1ns/1ps
module tb_swc_rd_sched;
    localparam int NP  = 4;
    localparam int PW  = 10;
    localparam int BW  = 2;
    localparam int DW  = 128;
    localparam int MW  = 4;
    localparam int LAT = 1;
    localparam int NB  = 1 << BW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NP-1:0]     q_rdy = '0;
    logic [NP*16-1:0]  q_ptr = '0;
    logic [NP-1:0]     q_ack;
    logic [NP-1:0]     o_bp = '0;
    logic              mc_wr = 1'b0;
    logic [PW-1:0]     mc_addr = '0;
    logic [MW-1:0]     mc_cnt = '0;
    logic              sram_rd;
    logic [PW+BW-1:0]  sram_addr;
    logic [DW-1:0]     sram_dout = '0;
    logic [NP-1:0]     o_wr;
    logic [DW-1:0]     o_din;
    logic              o_first, o_last, fq_wr, err_mc;
    logic [PW-1:0]     fq_din;

    always #5 clk = ~clk;

    swc_rd_sched #(
        .NPORT(NP), .PTR_W(PW), .BEAT_W(BW),
        .DATA_W(DW), .MC_W(MW), .RAM_LAT(LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .q_rdy(q_rdy), .q_ptr(q_ptr),
        .q_ack(q_ack), .o_bp(o_bp), .mc_wr(mc_wr), .mc_addr(mc_addr),
        .mc_cnt(mc_cnt), .sram_rd(sram_rd), .sram_addr(sram_addr),
        .sram_dout(sram_dout), .o_wr(o_wr), .o_din(o_din),
        .o_first(o_first), .o_last(o_last), .fq_wr(fq_wr),
        .fq_din(fq_din), .err_mc(err_mc)
    );

    function automatic logic [DW-1:0] pat(input logic [PW+BW-1:0] a);
        return {4{20'hC0DE0, a}};
    endfunction

    always @(posedge clk) if (sram_rd) sram_dout <= pat(sram_addr);

    typedef struct packed {
        logic [NP-1:0]    oh;
        logic [PW+BW-1:0] a;
        logic             f;
        logic             l;
    } beat_t;

    logic [15:0] bq [NP][$];
    logic [15:0] ld [NP][$];
    beat_t       exp_b [$];
    logic [PW-1:0] exp_fq [$];
    int          glog [$];
    int          mc_m [1<<PW];
    bit          err_exp, err_ok;
    int          checks = 0, errors = 0, fq_cnt = 0;
    beat_t       cb;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Output queue controllers: pop on ack, present the new head.
    always @(negedge clk) begin
        for (int n = 0; n < NP; n++) begin
            if (rstn && q_ack[n] && bq[n].size() > 0)
                void'(bq[n].pop_front());
            q_rdy[n] = bq[n].size() > 0;
            q_ptr[16*n +: 16] = q_rdy[n] ? bq[n][0] : 16'h0;
        end
    end

    always @(negedge clk)
        if (rstn)
            for (int n = 0; n < NP; n++)
                if (q_ack[n]) glog.push_back(n);

    always @(negedge clk) begin
        if (rstn) begin
            if (o_wr != '0) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL o_wr_extra: got %b want none", o_wr);
                end else begin
                    cb = exp_b.pop_front();
                    chk("o_wr", 128'(o_wr), 128'(cb.oh));
                    chk("o_din", 128'(o_din), 128'(pat(cb.a)));
                    chk("o_first", 128'(o_first), 128'(cb.f));
                    chk("o_last", 128'(o_last), 128'(cb.l));
                end
            end
            if (fq_wr) begin
                fq_cnt++;
                if (exp_fq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fq_extra: got %0h want none", fq_din);
                end else begin
                    chk("fq_din", 128'(fq_din), 128'(exp_fq.pop_front()));
                end
            end
            if (!err_ok) chk("err_mc_quiet", 128'(err_mc), 128'(0));
        end
    end

    task automatic expect_cell(input int p, input logic [15:0] e);
        beat_t b;
        int a;
        for (int k = 0; k < NB; k++) begin
            b.oh = NP'(1) << p;
            b.a  = {e[PW-1:0], BW'(k)};
            b.f  = e[14];
            b.l  = e[15];
            exp_b.push_back(b);
        end
        a = int'(e[PW-1:0]);
        if (mc_m[a] == 0) begin
            err_exp = 1'b1;
        end else begin
            mc_m[a]--;
            if (mc_m[a] == 0) exp_fq.push_back(e[PW-1:0]);
        end
    endtask

    function automatic int ld_total();
        int t = 0;
        for (int n = 0; n < NP; n++) t += ld[n].size();
        return t;
    endfunction

    // Serve every loaded cell in round-robin order starting at port 0.
    task automatic predict();
        int rr, g;
        logic [15:0] e;
`ifdef SWC_PKT_LOCK_EN
        int lk = -1;
`endif
        rr = 0;
        while (ld_total() > 0) begin
            g = -1;
`ifdef SWC_PKT_LOCK_EN
            if (lk >= 0 && ld[lk].size() > 0) g = lk;
`endif
            for (int i = 0; i < NP && g < 0; i++)
                if (ld[(rr + i) % NP].size() > 0) g = (rr + i) % NP;
            e = ld[g].pop_front();
            expect_cell(g, e);
            rr = (g + 1) % NP;
`ifdef SWC_PKT_LOCK_EN
            if (!e[15]) lk = g;
            else if (lk == g) lk = -1;
`endif
        end
    endtask

    task automatic load(input int p, input logic [15:0] e);
        bq[p].push_back(e);
        ld[p].push_back(e);
    endtask

    task automatic clear_all();
        exp_b.delete();
        exp_fq.delete();
        glog.delete();
        for (int n = 0; n < NP; n++) begin
            bq[n].delete();
            ld[n].delete();
        end
        o_bp = '0;
        err_exp = 1'b0;
        err_ok = 1'b0;
        fq_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic mc_write(input logic [PW-1:0] a, input int c);
        @(negedge clk);
        mc_wr = 1'b1;
        mc_addr = a;
        mc_cnt = MW'(c);
        mc_m[int'(a)] = c;
        @(negedge clk);
        mc_wr = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_b.size() > 0 || exp_fq.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, 128'(exp_b.size() + exp_fq.size()), 128'(0));
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [31:0] glog_pack();
        logic [31:0] v = '0;
        foreach (glog[i]) v = {v[27:0], 4'(glog[i])};
        return v;
    endfunction

    task automatic chk_order(input string nm, input int len, input logic [31:0] exp);
        chk({nm, "_ngrant"}, 128'(glog.size()), 128'(len));
        chk({nm, "_order"}, 128'(glog_pack()), 128'(exp));
    endtask

    task automatic wait_owr(input string nm);
        int n = 0;
        while (o_wr == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({nm, "_owr_seen"}, 128'(0), 128'(1));
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_q_ack"}, 128'(q_ack), 128'(0));
        chk({nm, "_sram_rd"}, 128'(sram_rd), 128'(0));
        chk({nm, "_sram_addr"}, 128'(sram_addr), 128'(0));
        chk({nm, "_o_wr"}, 128'(o_wr), 128'(0));
        chk({nm, "_o_din"}, 128'(o_din), 128'(0));
        chk({nm, "_o_flags"}, 128'({o_first, o_last}), 128'(0));
        chk({nm, "_fq"}, 128'({fq_wr, fq_din}), 128'(0));
        chk({nm, "_err_mc"}, 128'(err_mc), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gaps;
        clear_all();
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rstn = 1'b1;

        // Single unicast cell with hand-computed timing.
        mc_write(10'h005, 1);
        @(negedge clk);
        load(0, 16'hC005);
        predict();
        n = 0;
        while (q_ack == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_ack", 128'(q_ack), 128'(4'b0001));
        chk("t1_rd", 128'(sram_rd), 128'(1));
        chk("t1_addr0", 128'(sram_addr), 128'(12'h014));
        @(negedge clk);
        chk("t1_ack_pulse", 128'(q_ack), 128'(0));
        chk("t1_addr1", 128'(sram_addr), 128'(12'h015));
        chk("t1_owr", 128'(o_wr), 128'(4'b0001));
        @(negedge clk);
        chk("t1_addr2", 128'(sram_addr), 128'(12'h016));
        chk("t1_fq_wr", 128'(fq_wr), 128'(1));
        chk("t1_fq_din", 128'(fq_din), 128'(10'h005));
        @(negedge clk);
        chk("t1_addr3", 128'(sram_addr), 128'(12'h017));
        wait_done("t1");
        chk("t1_fq_once", 128'(fq_cnt), 128'(1));

        // Round-robin across all ports, back-to-back.
        do_reset();
        for (int i = 0; i < 5; i++) mc_write(PW'(16 + i), 1);
        @(negedge clk);
        load(0, 16'hC010);
        load(1, 16'hC011);
        load(2, 16'hC012);
        load(3, 16'hC013);
        load(0, 16'hC014);
        predict();
        wait_owr("rr");
        gaps = 0;
        for (int k = 0; k < 5 * NB; k++) begin
            if (o_wr == '0) gaps++;
            @(negedge clk);
        end
        chk("rr_gaps", 128'(gaps), 128'(0));
        wait_done("rr");
        chk_order("rr", 5, 32'h01230);

        // Multicast to three ports; one pointer return.
        do_reset();
        mc_write(10'h0A0, 3);
        @(negedge clk);
        load(1, 16'hC0A0);
        load(2, 16'hC0A0);
        load(3, 16'hC0A0);
        predict();
        wait_done("mc");
        chk_order("mc", 3, 32'h123);
        chk("mc_fq_once", 128'(fq_cnt), 128'(1));

        // Same pointer again: its count is now zero.
        err_ok = 1'b1;
        load(0, 16'hC0A0);
        predict();
        wait_done("err");
        chk("err_mc_set", 128'(err_mc), 128'(err_exp));
        chk("err_no_fq", 128'(fq_cnt), 128'(1));

        // Reset in the middle of a cell.
        mc_write(10'h033, 1);
        @(negedge clk);
        load(2, 16'hC033);
        predict();
        wait_owr("mid");
        rstn = 1'b0;
        clear_all();
        #1;
        chk_quiet("mid_rst");
        @(posedge clk);
        #1;
        chk_quiet("mid_rst_next");
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_fq", 128'(fq_cnt), 128'(0));

        // Backpressure holds port 1 until released.
        do_reset();
        mc_write(10'h040, 1);
        mc_write(10'h041, 1);
        @(negedge clk);
        o_bp = 4'b0010;
        load(0, 16'hC040);
        load(1, 16'hC041);
        expect_cell(0, ld[0].pop_front());
        expect_cell(1, ld[1].pop_front());
        repeat (20) @(negedge clk);
        chk_order("bp_held", 1, 32'h0);
        chk("bp_q1_waiting", 128'(bq[1].size()), 128'(1));
        o_bp = '0;
        wait_done("bp");
        chk_order("bp", 2, 32'h01);

        // Multi-cell packet on port 0 racing port 1.
        do_reset();
        mc_write(10'h100, 1);
        mc_write(10'h101, 1);
        mc_write(10'h102, 1);
        mc_write(10'h110, 1);
        mc_write(10'h111, 1);
        @(negedge clk);
        load(0, 16'h4100);
        load(0, 16'h0101);
        load(0, 16'h8102);
        load(1, 16'hC110);
        load(1, 16'hC111);
        predict();
        wait_done("pkt");
`ifdef SWC_PKT_LOCK_EN
        chk_order("pkt", 5, 32'h00011);
`else
        chk_order("pkt", 5, 32'h01010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
